// File: rtl/vec_pipe_reg.sv
// vec_pipe_reg
// Elastic vector pipeline register. A VEC_LENGTH-lane signed vector moves
// through DEPTH register stages under a valid/ready handshake. Empty stages
// always load, so bubbles collapse while the consumer stalls. Lanes whose
// mask bit is clear are stored as zero. Flush drops every in-flight vector
// synchronously.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   reset      asynchronous active-high reset, clears valid bits and data
//   in         input vector, VEC_LENGTH signed lanes of DATA_WIDTH bits
//   in_mask    per-lane keep mask, a clear bit stores that lane as zero
//   in_valid   input vector present
//   in_ready   pipeline accepts input this cycle
//   flush      synchronous drop of all in-flight vectors
//   out        data held by the last stage
//   out_valid  last stage holds a valid vector
//   out_ready  consumer accepts out this cycle
//   count      number of stages holding a valid vector (0..DEPTH)
module vec_pipe_reg #(
    parameter int DATA_WIDTH = 8,
    parameter int VEC_LENGTH = 8,
    parameter int DEPTH      = 2,
    localparam int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic signed [DATA_WIDTH-1:0] in [VEC_LENGTH-1:0],
    input  logic [VEC_LENGTH-1:0]        in_mask,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         flush,
    output logic signed [DATA_WIDTH-1:0] out [VEC_LENGTH-1:0],
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CNT_W-1:0]             count
);

    logic [DEPTH-1:0]             v;
    logic signed [DATA_WIDTH-1:0] d [DEPTH-1:0][VEC_LENGTH-1:0];
    logic [DEPTH:0]               r;

    // Ready ripples backwards from the consumer: a stage can take new data
    // when it is empty or when the stage after it is moving this cycle.
    always_comb begin
        r        = '0;
        r[DEPTH] = out_ready;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            r[k] = !v[k] || r[k+1];
        end
    end

    assign in_ready  = r[0] && !flush;
    assign out_valid = v[DEPTH-1];

    always_comb begin
        for (int j = 0; j < VEC_LENGTH; j++) begin
            out[j] = d[DEPTH-1][j];
        end
    end

    always_comb begin
        count = '0;
        for (int k = 0; k < DEPTH; k++) begin
            count = count + CNT_W'(v[k]);
        end
    end

    // Flush clears only the valid bits; data is left in place because it is
    // never observed without a valid bit. A stage loading a bubble keeps its
    // old data so that only valid vectors ever toggle the data registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                for (int j = 0; j < VEC_LENGTH; j++) begin
                    d[k][j] <= '0;
                end
            end
        end else if (flush) begin
            v <= '0;
        end else begin
            if (r[0]) begin
                v[0] <= in_valid;
                if (in_valid) begin
                    for (int j = 0; j < VEC_LENGTH; j++) begin
                        d[0][j] <= in_mask[j] ? in[j] : '0;
                    end
                end
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (r[k]) begin
                    v[k] <= v[k-1];
                    if (v[k-1]) begin
                        for (int j = 0; j < VEC_LENGTH; j++) begin
                            d[k][j] <= d[k-1][j];
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_vec_pipe_reg.sv
// tb_vec_pipe_reg
// Self-checking bench for vec_pipe_reg with DEPTH=3, eight 8-bit lanes.
// Accepted vectors are masked by a bench-side function and queued; every
// output transfer pops the queue and compares. Occupancy and in_ready are
// predicted from the queue size and the current handshake inputs.
module tb_vec_pipe_reg;

    localparam int DW    = 8;
    localparam int VL    = 8;
    localparam int DEPTH = 3;

    logic                 clk;
    logic                 reset;
    logic signed [DW-1:0] in_vec [VL-1:0];
    logic [VL-1:0]        in_mask;
    logic                 in_valid;
    logic                 in_ready;
    logic                 flush;
    logic signed [DW-1:0] out_vec [VL-1:0];
    logic                 out_valid;
    logic                 out_ready;
    logic [1:0]           count;

    logic [DW*VL-1:0] in_flat;
    logic [DW*VL-1:0] out_flat;
    logic [DW*VL-1:0] q [$];

    int tests = 0;
    int fails = 0;

    vec_pipe_reg #(.DATA_WIDTH(DW), .VEC_LENGTH(VL), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in        (in_vec),
        .in_mask   (in_mask),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .out       (out_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_comb begin
        for (int j = 0; j < VL; j++) begin
            in_vec[j]           = in_flat[j*DW +: DW];
            out_flat[j*DW +: DW] = out_vec[j];
        end
    end

    function automatic logic [DW*VL-1:0] maskVec(input logic [DW*VL-1:0] vec, input logic [VL-1:0] m);
        logic [DW*VL-1:0] res;
        for (int j = 0; j < VL; j++) begin
            res[j*DW +: DW] = m[j] ? vec[j*DW +: DW] : '0;
        end
        return res;
    endfunction

    function automatic logic [DW*VL-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives one cycle of inputs, runs the scoreboard at the negedge before
    // the active edge, then returns 1 time unit after that edge.
    task automatic applyStimulus(input logic vld, input logic [DW*VL-1:0] vec,
                                 input logic [VL-1:0] m, input logic ordy, input logic fl);
        int               sz;
        logic             exp_ready;
        logic [DW*VL-1:0] exp_v;
        in_valid  = vld;
        in_flat   = vec;
        in_mask   = m;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        sz        = q.size();
        exp_ready = !fl && ((sz < DEPTH) || ordy);
        checkOutput("count", 64'(count), 64'(sz));
        checkOutput("in_ready", 64'(in_ready), 64'(exp_ready));
        if (out_valid && ordy) begin
            if (q.size() != 0) exp_v = q.pop_front();
            else               exp_v = 'x;
            checkOutput("out_data", out_flat, exp_v);
        end
        if (vld && exp_ready) q.push_back(maskVec(vec, m));
        if (fl) q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic ordy, input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '1, ordy, 1'b0);
    endtask

    initial begin
        logic [DW*VL-1:0] va;
        logic [DW*VL-1:0] mv;
        logic [DW*VL-1:0] mexp;
        int               waited;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_flat   = '0;
        in_mask   = '1;
        out_ready = 1'b0;
        flush     = 1'b0;
        #1;
        checkOutput("rst0_out", out_flat, 64'h0);
        checkOutput("rst0_valid", 64'(out_valid), 64'h0);
        checkOutput("rst0_count", 64'(count), 64'h0);
        checkOutput("rst0_ready", 64'(in_ready), 64'h1);
        #2 reset = 1'b0;
        @(posedge clk);
        #1;

        // Latency and streaming with the consumer always ready.
        va = rnd64();
        applyStimulus(1'b1, va, '1, 1'b1, 1'b0);
        checkOutput("lat_edge0", 64'(out_valid), 64'h0);
        applyStimulus(1'b1, rnd64(), '1, 1'b1, 1'b0);
        checkOutput("lat_edge1", 64'(out_valid), 64'h0);
        applyStimulus(1'b1, rnd64(), '1, 1'b1, 1'b0);
        checkOutput("lat_edge2", 64'(out_valid), 64'h1);
        checkOutput("lat_data", out_flat, va);
        applyStimulus(1'b1, rnd64(), '1, 1'b1, 1'b0);
        checkOutput("stream_count", 64'(count), 64'h3);
        idle(1'b1, 4);

        // Backpressure: fill, then release with continuous input.
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, rnd64(), '1, 1'b0, 1'b0);
        checkOutput("bp_count", 64'(count), 64'h3);
        checkOutput("bp_ready", 64'(in_ready), 64'h0);
        checkOutput("bp_valid", 64'(out_valid), 64'h1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, rnd64(), '1, 1'b1, 1'b0);
        idle(1'b1, 4);

        // Bubble collapsing under a stalled consumer.
        applyStimulus(1'b1, rnd64(), '1, 1'b0, 1'b0);
        applyStimulus(1'b0, rnd64(), '1, 1'b0, 1'b0);
        applyStimulus(1'b1, rnd64(), '1, 1'b0, 1'b0);
        applyStimulus(1'b1, rnd64(), '1, 1'b0, 1'b0);
        checkOutput("bub_count", 64'(count), 64'h3);
        checkOutput("bub_valid", 64'(out_valid), 64'h1);
        applyStimulus(1'b1, rnd64(), '1, 1'b0, 1'b0);
        idle(1'b1, 4);

        // Lane masking with sign-extreme values, lane 0 in the low byte.
        mv   = 64'hC0_40_FB_05_00_FF_80_7F;
        mexp = 64'hC0_00_FB_00_00_00_80_00;
        applyStimulus(1'b1, mv, 8'b1010_1010, 1'b1, 1'b0);
        waited = 0;
        while (!out_valid && waited < 8) begin
            idle(1'b1, 1);
            waited++;
        end
        checkOutput("mask_seen", 64'(out_valid), 64'h1);
        checkOutput("mask_lanes", out_flat, mexp);
        idle(1'b1, 3);

        // Flush a full pipe while input is offered.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, rnd64(), '1, 1'b0, 1'b0);
        checkOutput("pre_flush_count", 64'(count), 64'h3);
        applyStimulus(1'b1, rnd64(), '1, 1'b0, 1'b1);
        checkOutput("flush_count", 64'(count), 64'h0);
        checkOutput("flush_valid", 64'(out_valid), 64'h0);
        idle(1'b1, 2);

        // Asynchronous reset in the middle of a stream.
        applyStimulus(1'b1, rnd64(), '1, 1'b0, 1'b0);
        applyStimulus(1'b1, rnd64(), '1, 1'b0, 1'b0);
        #3;
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        checkOutput("rst_out", out_flat, 64'h0);
        checkOutput("rst_valid", 64'(out_valid), 64'h0);
        checkOutput("rst_count", 64'(count), 64'h0);
        checkOutput("rst_ready", 64'(in_ready), 64'h1);
        q.delete();
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        va = rnd64();
        applyStimulus(1'b1, va, '1, 1'b1, 1'b0);
        checkOutput("rlat_edge0", 64'(out_valid), 64'h0);
        idle(1'b1, 1);
        checkOutput("rlat_edge1", 64'(out_valid), 64'h0);
        idle(1'b1, 1);
        checkOutput("rlat_edge2", 64'(out_valid), 64'h1);
        checkOutput("rlat_data", out_flat, va);
        idle(1'b1, 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vec_pipe_reg.md
# vec_pipe_reg

Parametrised elastic vector pipeline register: carries a VEC_LENGTH-lane signed vector through DEPTH register stages with a valid/ready handshake, bubble collapsing, per-lane zero masking and synchronous flush. It sits between vector producers and consumers (PE array inputs, accumulator outputs) wherever a retiming stage must tolerate downstream backpressure. With DEPTH=1 and out_ready tied high it degenerates to a plain per-lane vector register.

## Interface
- DATA_WIDTH, 8, bits per lane (signed)
- VEC_LENGTH, 8, number of lanes
- DEPTH, 2, number of register stages (>=1)
- CNT_W, $clog2(DEPTH+1), width of occupancy count (derived, not overridden)

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- in  in  signed [DATA_WIDTH-1:0] x [VEC_LENGTH-1:0]  input vector
- in_mask  in  VEC_LENGTH  per-lane keep mask; bit j=0 stores lane j as 0
- in_valid  in  1  input vector present
- in_ready  out  1  pipeline accepts input this cycle
- flush  in  1  synchronous drop of all in-flight vectors
- out  out  signed [DATA_WIDTH-1:0] x [VEC_LENGTH-1:0]  last-stage data
- out_valid  out  1  last stage holds a valid vector
- out_ready  in  1  consumer accepts out this cycle
- count  out  CNT_W  number of valid stages (0..DEPTH)

## Operation
- State per stage k (0..DEPTH-1): valid bit v[k], data d[k] (VEC_LENGTH lanes). out = d[DEPTH-1], out_valid = v[DEPTH-1].
- Ready chain (combinational): r[DEPTH] = out_ready; r[k] = !v[k] || r[k+1]. in_ready = r[0] && !flush.
- Stage 0 loads when r[0]: v[0] <= in_valid && !flush; if in_valid, d[0][j] <= in_mask[j] ? in[j] : 0.
- Stage k>0 loads from k-1 when r[k]: v[k] <= v[k-1]; d[k] <= d[k-1] only if v[k-1] (bubbles do not overwrite data).
- Stage with r[k]=0 holds v and d.
- Bubble collapsing: an empty stage always loads, so gaps close while downstream stalls.
- Transfer on output: out_valid && out_ready at edge; on input: in_valid && in_ready.
- flush=1 at edge: all v[k] <= 0, no input accepted, d unchanged; flush overrides simultaneous input and output transfers (output transfer in that cycle is still counted as consumed by the consumer; the vector is dropped regardless).
- count = popcount(v), registered-state derived (combinational from v).
- Data passes unmodified except masking; no arithmetic, no width change, sign preserved.
- Reset: all v=0, all d=0, so out=0, out_valid=0, count=0; in_ready=1 (when flush=0) from reset assertion onward. Reset mid-stream discards all in-flight vectors.

## Timing
- Latency: vector accepted at edge t appears at out with out_valid=1 after edge t+DEPTH-1 (DEPTH=1: visible the cycle after acceptance).
- Throughput: 1 vector/cycle with out_ready held high.
- in_ready depends combinationally on out_ready and v; full pipe with out_ready=1 still accepts input same cycle.
- Full pipe (count=DEPTH) with out_ready=0: in_ready=0; out and out_valid stable until out_ready=1.
- out must not change while out_valid=1 and out_ready=0.
- Reset assertion takes effect without a clock edge; deassertion synchronous to design usage (first edge after deassert may accept input).

## Test plan
- DEPTH=3, stream vectors A,B,C,D with in_mask=all ones, out_ready=1 -> A on out 3 cycles after acceptance, then B,C,D on consecutive cycles, count steady at 3.
- DEPTH=3, out_ready=0, in_valid=1 continuously -> exactly 3 accepted, in_ready=0, count=3; raise out_ready -> one vector out and one in per cycle, order preserved.
- Insert bubble (in_valid=0 one cycle) while out_ready=0 -> bubble collapses, pipe fills to count=3 with no gap in output order.
- in lane values {127,-128,-1,0,5,-5,64,-64}, in_mask=8'b1010_1010 -> out lanes {0,-128,0,0,0,-5,0,-64} (lane 0 first), sign intact.
- Pipe full, assert flush with in_valid=1 -> next cycle count=0, out_valid=0, input not accepted, in_ready=0 during flush.
- Assert reset asynchronously mid-stream -> out=0, out_valid=0, count=0 immediately; after deassert, new vector emerges with normal DEPTH latency.
